// File: rtl/cdc_arb_pkg.sv
// Shared definitions for the CDC transmit arbiter: FSM state encoding and a
// width helper.
package cdc_arb_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_SEND = S_SEND,
        ST_WAIT = S_WAIT
    } state_e;

    // Index width for n items, never less than 1 bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: rotate requests so rr_ptr_i sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_arbiter
    import cdc_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] rr_ptr_i,
    output logic [N-1:0]  win_oh_o,
    output logic [IW-1:0] win_idx_o
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [IW-1:0]  offset;
    logic [IW:0]    idx_sum;

    assign req_dbl = {req_i, req_i} >> rr_ptr_i;
    assign req_rot = req_dbl[N-1:0];

    // NOTE: offset gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) offset = IW'(i);
        end
    end

    assign idx_sum   = {1'b0, offset} + {1'b0, rr_ptr_i};
    assign win_idx_o = (idx_sum >= (IW+1)'(N)) ? IW'(idx_sum - (IW+1)'(N))
                                               : idx_sum[IW-1:0];
    assign win_oh_o  = (|req_i) ? (N'(1) << win_idx_o) : '0;

endmodule

// File: rtl/cdc_tx_arb.sv
// Source-domain scheduler sharing one single-word CDC handshake channel
// between N requesters, with round-robin arbitration and a sticky busy timeout.
module cdc_tx_arb
    import cdc_arb_pkg::*;
#(
    parameter  int N       = 4,
    parameter  int DW      = 8,
    parameter  int TO_W    = 16,
    parameter  int TIMEOUT = 1000,
    localparam int IW      = clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] req_dat,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic            ch_vld,
    output logic [DW-1:0]   ch_dat,
    input  logic            ch_busy,
    output logic            timeout,
    input  logic            clr_to,
    output logic [IW-1:0]   cur_id
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT - 1);

    state_e          state_q;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N-1:0]    gnt_q, done_q;
    logic            ch_vld_q, timeout_q;
    logic [DW-1:0]   ch_dat_q, ch_dat_d;
    logic [IW-1:0]   cur_id_q;
    logic [TO_W-1:0] wait_cnt_q;

    logic [N-1:0]    win_oh;
    logic [IW-1:0]   win_idx;

    rr_arbiter #(.N(N)) u_rr_arbiter (
        .req_i     (req),
        .rr_ptr_i  (rr_ptr_q),
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx)
    );

    assign ch_dat_d = req_dat[win_idx*DW +: DW];
    assign rr_ptr_d = (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            ch_vld_q   <= 1'b0;
            ch_dat_q   <= '0;
            cur_id_q   <= '0;
            timeout_q  <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            gnt_q    <= '0;
            done_q   <= '0;
            ch_vld_q <= 1'b0;
            if (clr_to) timeout_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // A stale busy means the channel still holds a word; do not grant.
                    if ((|req) && !ch_busy) begin
                        gnt_q    <= win_oh;
                        ch_dat_q <= ch_dat_d;
                        cur_id_q <= win_idx;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    ch_vld_q   <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Busy cannot rise while the valid pulse is still on the wire.
                    if (!ch_busy && !ch_vld_q) begin
                        done_q  <= N'(1) << cur_id_q;
                        state_q <= ST_IDLE;
                    end else if (ch_busy) begin
                        if (wait_cnt_q != '1) wait_cnt_q <= wait_cnt_q + 1'b1;
                        if (wait_cnt_q >= TO_LIM) timeout_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign ch_vld  = ch_vld_q;
    assign ch_dat  = ch_dat_q;
    assign cur_id  = cur_id_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_cdc_tx_arb.sv
// Directed bench for cdc_tx_arb: a cycle table with hand-driven busy, then
// sequences against a small channel model for contention, timeout and reset.
module tb_cdc_tx_arb;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_dat;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic            ch_vld;
    logic [DW-1:0]   ch_dat;
    logic            ch_busy;
    logic            timeout;
    logic            clr_to;
    logic [1:0]      cur_id;

    logic            busy_tbl;
    logic            model_en;
    int              busy_len;
    int              busy_left;

    int n_cmp;
    int n_fail;

    cdc_tx_arb #(.N(N), .DW(DW), .TO_W(16), .TIMEOUT(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_dat (req_dat),
        .gnt     (gnt),
        .done    (done),
        .ch_vld  (ch_vld),
        .ch_dat  (ch_dat),
        .ch_busy (ch_busy),
        .timeout (timeout),
        .clr_to  (clr_to),
        .cur_id  (cur_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel model: latches valid on the edge, then busy for busy_len cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) busy_left <= 0;
        else if (ch_vld) busy_left <= busy_len;
        else if (busy_left != 0) busy_left <= busy_left - 1;
    end
    assign ch_busy = model_en ? (busy_left != 0) : busy_tbl;

    // {gnt, done, ch_vld, ch_dat, cur_id, timeout}
    logic [19:0] outs;
    assign outs = {gnt, done, ch_vld, ch_dat, cur_id, timeout};

    typedef struct {
        logic [3:0]  req;
        logic [31:0] dat;
        logic        busy;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[$];

    localparam logic [31:0] D0 = 32'h44A5_2211;
    localparam logic [31:0] D1 = 32'h445A_2211;

    task automatic add_row(input logic [3:0] r, input logic [31:0] d, input logic b,
                           input logic [3:0] g, input logic [3:0] dn, input logic v,
                           input logic [7:0] cd, input logic [1:0] id);
        vec_t row;
        row.req  = r;
        row.dat  = d;
        row.busy = b;
        row.exp  = {g, dn, v, cd, id, 1'b0};
        tbl.push_back(row);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // which: 0 = gnt, 1 = ch_vld, 2 = done. Bounded so a stuck DUT still ends.
    task automatic wait_for(input int which, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if ((which == 0 && gnt != '0) || (which == 1 && ch_vld) ||
                (which == 2 && done != '0)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_xfer(input int id, input logic [7:0] exp_dat);
        logic       ok;
        logic [3:0] oh;
        oh = 4'b0001 << id;
        wait_for(0, ok);
        check($sformatf("xfer%0d_gnt", id), {27'd0, ok, gnt}, {27'd0, 1'b1, oh});
        check($sformatf("xfer%0d_id", id), 32'(cur_id), 32'(id));
        wait_for(1, ok);
        check($sformatf("xfer%0d_dat", id), {23'd0, ok, ch_dat}, {23'd0, 1'b1, exp_dat});
        wait_for(2, ok);
        check($sformatf("xfer%0d_done", id), {27'd0, ok, done}, {27'd0, 1'b1, oh});
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic ok;
        n_cmp    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req      = '0;
        req_dat  = '0;
        clr_to   = 1'b0;
        busy_tbl = 1'b0;
        model_en = 1'b0;
        busy_len = 0;

        //        req      dat busy  gnt      done     vld  dat    id
        add_row(4'b0001, D0, 1, 4'b0000, 4'b0000, 0, 8'h00, 2'd0);
        add_row(4'b0001, D0, 1, 4'b0000, 4'b0000, 0, 8'h00, 2'd0);
        add_row(4'b0001, D0, 0, 4'b0001, 4'b0000, 0, 8'h11, 2'd0);
        add_row(4'b0000, D0, 0, 4'b0000, 4'b0000, 1, 8'h11, 2'd0);
        add_row(4'b0000, D0, 0, 4'b0000, 4'b0000, 0, 8'h11, 2'd0);
        add_row(4'b0000, D0, 1, 4'b0000, 4'b0000, 0, 8'h11, 2'd0);
        add_row(4'b0000, D0, 0, 4'b0000, 4'b0001, 0, 8'h11, 2'd0);
        add_row(4'b0100, D0, 0, 4'b0100, 4'b0000, 0, 8'hA5, 2'd2);
        add_row(4'b0000, D1, 0, 4'b0000, 4'b0000, 1, 8'hA5, 2'd2);
        add_row(4'b0000, D1, 0, 4'b0000, 4'b0000, 0, 8'hA5, 2'd2);
        for (int i = 0; i < 6; i++)
            add_row(4'b0000, D1, 1, 4'b0000, 4'b0000, 0, 8'hA5, 2'd2);
        add_row(4'b0000, D1, 0, 4'b0000, 4'b0100, 0, 8'hA5, 2'd2);
        add_row(4'b0000, D1, 0, 4'b0000, 4'b0000, 0, 8'hA5, 2'd2);
        add_row(4'b1010, D1, 0, 4'b1000, 4'b0000, 0, 8'h44, 2'd3);
        add_row(4'b0010, D1, 0, 4'b0000, 4'b0000, 1, 8'h44, 2'd3);
        add_row(4'b0010, D1, 0, 4'b0000, 4'b0000, 0, 8'h44, 2'd3);
        add_row(4'b0010, D1, 1, 4'b0000, 4'b0000, 0, 8'h44, 2'd3);
        add_row(4'b0010, D1, 0, 4'b0000, 4'b1000, 0, 8'h44, 2'd3);
        add_row(4'b0010, D1, 0, 4'b0010, 4'b0000, 0, 8'h22, 2'd1);
        add_row(4'b0000, D1, 0, 4'b0000, 4'b0000, 1, 8'h22, 2'd1);
        add_row(4'b0000, D1, 0, 4'b0000, 4'b0000, 0, 8'h22, 2'd1);
        add_row(4'b0000, D1, 1, 4'b0000, 4'b0000, 0, 8'h22, 2'd1);
        add_row(4'b0000, D1, 0, 4'b0000, 4'b0010, 0, 8'h22, 2'd1);
        add_row(4'b0000, D1, 0, 4'b0000, 4'b0000, 0, 8'h22, 2'd1);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(outs), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            req      = tbl[i].req;
            req_dat  = tbl[i].dat;
            busy_tbl = tbl[i].busy;
            @(posedge clk);
            #1;
            check($sformatf("row%0d", i), 32'(outs), 32'(tbl[i].exp));
        end

        // Contention: all four held, order 0,1,2,3,0 from a fresh pointer.
        pulse_reset();
        model_en = 1'b1;
        busy_len = 3;
        req_dat  = 32'hD4C3_B2A1;
        req      = 4'b1111;
        run_xfer(0, 8'hA1);
        run_xfer(1, 8'hB2);
        run_xfer(2, 8'hC3);
        run_xfer(3, 8'hD4);
        run_xfer(0, 8'hA1);

        // Timeout: busy held 20 cycles, TIMEOUT = 8.
        @(negedge clk);
        req      = 4'b0001;
        busy_len = 20;
        wait_for(0, ok);
        check("to_gnt", {27'd0, ok, gnt}, {27'd0, 1'b1, 4'b0001});
        @(negedge clk);
        req = 4'b0000;
        wait_for(1, ok);
        check("to_vld", 32'(ok), 32'd1);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        check("to_before", 32'(timeout), 32'd0);
        @(posedge clk);
        #1;
        check("to_set", 32'(timeout), 32'd1);
        wait_for(2, ok);
        check("to_done", {27'd0, ok, done}, {27'd0, 1'b1, 4'b0001});
        check("to_sticky", 32'(timeout), 32'd1);
        @(negedge clk);
        clr_to = 1'b1;
        @(posedge clk);
        #1;
        check("to_clear", 32'(timeout), 32'd0);
        @(negedge clk);
        clr_to = 1'b0;

        // Reset in the middle of WAIT, then a fresh grant from requester 0.
        req      = 4'b0100;
        busy_len = 10;
        wait_for(0, ok);
        check("rst_gnt", {27'd0, ok, gnt}, {27'd0, 1'b1, 4'b0100});
        @(negedge clk);
        req = 4'b0000;
        wait_for(1, ok);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_outputs", 32'(outs), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        wait_for(0, ok);
        check("rst_regrant", {27'd0, ok, gnt}, {27'd0, 1'b1, 4'b0001});
        @(negedge clk);
        req = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
